jtcontra_snd_mailbox: RTL and testbench
=======================================

// Module: jtcontra_snd_mailbox
// PURPOSE
//  Main-to-sound command mailbox, downstream of the main CPU block. Captures each
//  sound command (latch byte + IRQ pulse) from the main CPU, queues it and raises
//  the sound CPU IRQ. Holds the IRQ until the sound CPU acknowledges it, and
//  releases the entry when the sound CPU reads the latch. Both CPUs run on clk
//  with independent clock enables.
// PARAMETERS
//  DEPTH  4  command queue depth. Power of two, 1..16. DEPTH=1 gives the PCB
//            behaviour: a single latch, with overwrite on a new command.
//  AW     $clog2(DEPTH) (min 1)  queue pointer width. Derived; do not override.
// PORTS
//  clk        in   1   system clock, 24 MHz
//  rst        in   1   reset: synchronous, active-high
//  main_latch in   8   sound latch byte from main CPU; stable before main_irq rises
//  main_irq   in   1   sound IRQ pulse from main CPU; level, >=1 clk wide
//  snd_cen    in   1   sound CPU clock enable
//  snd_rd     in   1   sound CPU read strobe on the latch address; qualified by snd_cen
//  snd_ack    in   1   sound CPU IRQ acknowledge; qualified by snd_cen
//  snd_dout   out  8   latch byte presented to the sound CPU
//  snd_irqn   out  1   sound CPU IRQ, active low
//  level      out  AW+1  number of queued entries
//  overflow   out  1   sticky: a push arrived while the queue was full
// BEHAVIOUR
//  - Reset values: snd_dout=8'hFF, snd_irqn=1, level=0, overflow=0, state=IDLE,
//    pointers=0. The edge-detect register resets to 0. Reset mid-operation drops
//    every queued entry and deasserts the IRQ on the next clk.
//  - Push: on a main_irq rising edge (main_irq & ~irq_l, with irq_l registered
//    every clk, no cen). main_latch is written at wr_ptr. Push needs no cen.
//  - Full push: DEPTH>1 overwrites the newest entry (wr_ptr-1); level and the
//    pointers are unchanged. DEPTH=1 overwrites the single entry. Both cases set
//    overflow. overflow clears only on rst.
//  - Head: snd_dout is registered and equals the entry at rd_ptr whenever
//    level>0. When empty, it keeps the last popped value.
//  - FSM, which advances only when snd_cen=1, except for IDLE->PEND:
//    IDLE: snd_irqn=1. level>0 -> PEND on the next clk (no cen needed).
//    PEND: snd_irqn=0. snd_ack -> SERV. snd_rd without an ack -> pop, then
//          PEND if level after the pop is >0, else IDLE.
//    SERV: snd_irqn=1. snd_rd -> pop, then PEND if level after the pop is >0,
//          else IDLE. snd_ack here is ignored.
//  - Pop: rd_ptr+1 and level-1, both modulo DEPTH. snd_rd while level=0 has no
//    effect and returns the held snd_dout.
//  - Simultaneous push and pop in one clk: both take effect and level is
//    unchanged. If full, the pop frees a slot first, so there is no overwrite
//    and no overflow. If empty, the pushed byte reaches snd_dout one clk later
//    and the pop is ignored.
//  - Latency: main_irq rise -> snd_irqn low = 2 clk (edge reg + state reg).
//    Pop -> next head on snd_dout = 1 clk.
//  - Pointer wrap: AW-bit counters wrap naturally. level is the only full/empty
//    indicator (full when level==DEPTH).
// STRUCTURE
//  - Shared include jtcontra_snd.vh: FSM encodings MBX_IDLE=2'd0,
//    MBX_PEND=2'd1, MBX_SERV=2'd2, and the empty read value 8'hFF.
//  - Sub-module jtcontra_snd_fifo: DEPTH x 8 register array, pointers, level,
//    full overwrite rule and the push/pop ports. It has no cen of its own.
//  - The top level holds the edge detect, the FSM, the snd_dout register and
//    the overflow flag.
// TESTING
//  1. Reset, then main_latch=8'h12 and a main_irq pulse -> snd_irqn=0 after
//     2 clk, snd_dout=8'h12, level=1.
//  2. snd_ack, then snd_rd, both with snd_cen -> snd_irqn high at the ack,
//     level=0 after the read, state IDLE, snd_dout holds 8'h12.
//  3. DEPTH=4: push 8'hA1..8'hA5 with no reads -> level=4, overflow=1,
//     entries A1,A2,A3,A5. Four ack/read cycles return A1,A2,A3,A5, with IRQ
//     re-asserted between each.
//  4. DEPTH=4: push and pop in the same clk while full -> level stays 4,
//     overflow stays 0.
//  5. DEPTH=1: push 8'h30, then 8'h31 before any read -> snd_dout=8'h31,
//     overflow=1, a single IRQ.
//  6. rst asserted in PEND with level=3 -> next clk snd_irqn=1, level=0,
//     snd_dout=8'hFF. A later snd_rd has no effect.

Source files
------------

// File: rtl/jtcontra_snd_mailbox_pkg.sv
// rtl/jtcontra_snd_mailbox_pkg.sv - shared types and constants for the sound command mailbox
// Contents:
//   mbx_state_t  sound-side IRQ handshake state (idle / IRQ pending / being serviced)
//   MBX_EMPTY    value shown on the sound data bus before any command was queued
//   mbx_aw()     queue pointer width for a given depth (at least 1 bit)

package jtcontra_snd_mailbox_pkg;

    typedef enum logic [1:0] {
        MBX_IDLE = 2'd0,
        MBX_PEND = 2'd1,
        MBX_SERV = 2'd2
    } mbx_state_t;

    localparam logic [7:0] MBX_EMPTY = 8'hFF;

    function automatic int mbx_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/jtcontra_snd_fifo.sv
// rtl/jtcontra_snd_fifo.sv - command queue storage, pointers and occupancy
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   push, din     write din this clk (overwrites newest entry when full and not popping)
//   pop           drop the head entry this clk (ignored when empty)
//   level         number of queued entries
//   nonempty_nxt  queue holds at least one entry after this clk
//   head_nxt      head entry as it will be after this clk
//   overwrite     this clk's push replaced the newest entry

module jtcontra_snd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [AW:0]   level,
    output logic          nonempty_nxt,
    output logic [7:0]    head_nxt,
    output logic          overwrite
);

    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Sized to the pointer range so indexing is always in bounds; with
    // DEPTH=1 only entry 0 is ever addressed.
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt, wr_idx;
    logic          pop_ok, wr_adv;

    // Pointers wrap modulo DEPTH, which also covers DEPTH=1 where AW is 1.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? LAST : p - 1'b1;
    endfunction

    always_comb begin
        pop_ok       = pop && (level != '0);
        // A pop in the same clk frees a slot, so a full queue is only
        // overwritten when nothing leaves it.
        overwrite    = push && (level == FULL) && !pop_ok;
        wr_adv       = push && !overwrite;
        wr_idx       = overwrite ? ptr_dec(wr_ptr) : wr_ptr;
        rd_nxt       = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        head_nxt     = (push && (wr_idx == rd_nxt)) ? din : mem[rd_nxt];
        nonempty_nxt = push || (level > (AW+1)'(pop_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            if (wr_adv) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (wr_adv && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!wr_adv && pop_ok) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/jtcontra_snd_mailbox.sv
// rtl/jtcontra_snd_mailbox.sv - main-to-sound CPU command mailbox with IRQ handshake
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   main_latch   command byte from the main CPU
//   main_irq     command strobe from the main CPU; each rising edge queues main_latch
//   snd_cen      sound CPU clock enable qualifying snd_rd / snd_ack
//   snd_rd       sound CPU read of the latch; releases the head entry
//   snd_ack      sound CPU IRQ acknowledge
//   snd_dout     head command byte (holds the last popped byte when empty)
//   snd_irqn     sound CPU IRQ, active low
//   level        queued entries
//   overflow     sticky: a command arrived while the queue was full

module jtcontra_snd_mailbox
    import jtcontra_snd_mailbox_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = mbx_aw(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  main_latch,
    input  logic        main_irq,
    input  logic        snd_cen,
    input  logic        snd_rd,
    input  logic        snd_ack,
    output logic [7:0]  snd_dout,
    output logic        snd_irqn,
    output logic [AW:0] level,
    output logic        overflow
);

    mbx_state_t state, state_nxt;
    logic       irq_l, push, pop, nonempty_nxt, overwrite;
    logic [7:0] head_nxt;

    assign push = main_irq & ~irq_l;

    jtcontra_snd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .din          (main_latch),
        .pop          (pop),
        .level        (level),
        .nonempty_nxt (nonempty_nxt),
        .head_nxt     (head_nxt),
        .overwrite    (overwrite)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_l    <= 1'b0;
            state    <= MBX_IDLE;
            snd_dout <= MBX_EMPTY;
            overflow <= 1'b0;
        end else begin
            irq_l <= main_irq;
            state <= state_nxt;
            // Registering the post-update head gives one clk from push or
            // pop to the new byte on snd_dout; when the queue drains the
            // last popped byte stays visible.
            if (nonempty_nxt) begin
                snd_dout <= head_nxt;
            end
            if (overwrite) begin
                overflow <= 1'b1;
            end
        end
    end

    // Only IDLE->PEND ignores snd_cen, so a queued command raises the IRQ
    // even while the sound CPU is stalled.
    always_comb begin
        state_nxt = state;
        snd_irqn  = 1'b1;
        pop       = 1'b0;
        case (state)
            MBX_IDLE: begin
                if (level != '0) begin
                    state_nxt = MBX_PEND;
                end
            end
            MBX_PEND: begin
                snd_irqn = 1'b0;
                if (snd_cen && snd_ack) begin
                    state_nxt = MBX_SERV;
                end else if (snd_cen && snd_rd) begin
                    pop       = 1'b1;
                    state_nxt = nonempty_nxt ? MBX_PEND : MBX_IDLE;
                end
            end
            MBX_SERV: begin
                if (snd_cen && snd_rd) begin
                    pop       = 1'b1;
                    state_nxt = nonempty_nxt ? MBX_PEND : MBX_IDLE;
                end
            end
            default: state_nxt = MBX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtcontra_snd_mailbox.sv
// tb/tb_jtcontra_snd_mailbox.sv - bench for jtcontra_snd_mailbox at DEPTH=4 and DEPTH=1

module tb_jtcontra_snd_mailbox;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] main_latch = 8'h00;
    logic       main_irq = 1'b0;
    logic       snd_cen = 1'b0;
    logic       snd_rd = 1'b0;
    logic       snd_ack = 1'b0;

    logic [7:0] d4_dout, d1_dout;
    logic       d4_irqn, d1_irqn, d4_ovf, d1_ovf;
    logic [2:0] d4_level;
    logic [1:0] d1_level;

    int asserts = 0;
    int fails   = 0;

    // Reference model: one command queue per DUT plus the handshake phase
    // (0 quiet, 1 IRQ raised, 2 acknowledged and being serviced).
    logic [7:0] mq [2][$];
    logic [7:0] md [2];
    int         mph [2];
    bit         movf [2];
    bit         mprev;

    always #5 clk = ~clk;

    jtcontra_snd_mailbox #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .main_latch(main_latch), .main_irq(main_irq),
        .snd_cen(snd_cen), .snd_rd(snd_rd), .snd_ack(snd_ack),
        .snd_dout(d4_dout), .snd_irqn(d4_irqn), .level(d4_level), .overflow(d4_ovf)
    );

    jtcontra_snd_mailbox #(.DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .main_latch(main_latch), .main_irq(main_irq),
        .snd_cen(snd_cen), .snd_rd(snd_rd), .snd_ack(snd_ack),
        .snd_dout(d1_dout), .snd_irqn(d1_irqn), .level(d1_level), .overflow(d1_ovf)
    );

    task automatic model_step(input int m);
        int dep, n0;
        bit push, rdq, ackq, pop;
        dep = (m == 0) ? 4 : 1;
        if (rst) begin
            mq[m].delete();
            md[m] = 8'hFF;
            mph[m] = 0;
            movf[m] = 1'b0;
            return;
        end
        push = main_irq && !mprev;
        rdq  = snd_cen && snd_rd;
        ackq = snd_cen && snd_ack;
        pop  = (mph[m] == 1 && rdq && !ackq) || (mph[m] == 2 && rdq);
        n0   = mq[m].size();
        if (pop && n0 > 0) void'(mq[m].pop_front());
        if (push) begin
            if (mq[m].size() == dep) begin
                mq[m][dep-1] = main_latch;
                movf[m] = 1'b1;
            end else begin
                mq[m].push_back(main_latch);
            end
        end
        if (mq[m].size() > 0) md[m] = mq[m][0];
        if (mph[m] == 0) begin
            if (n0 > 0) mph[m] = 1;
        end else if (mph[m] == 1 && ackq) begin
            mph[m] = 2;
        end else if (pop) begin
            mph[m] = (mq[m].size() > 0) ? 1 : 0;
        end
    endtask

    // One clock: model advances on the same edge as the DUTs, outputs are
    // then observed at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        mprev = rst ? 1'b0 : main_irq;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b);
        main_latch = b;
        main_irq = 1'b1;
        tick();
        main_irq = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        main_irq = 1'b0;
        snd_cen = 1'b0;
        snd_rd = 1'b0;
        snd_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        asserts++;
        if ({d4_dout, d4_irqn, d4_level, d4_ovf} !== {8'hFF, 1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_d4: got dout=%h irqn=%b level=%0d ovf=%b, want ff 1 0 0", d4_dout, d4_irqn, d4_level, d4_ovf);
        end
        asserts++;
        if ({d1_dout, d1_irqn, d1_level, d1_ovf} !== {8'hFF, 1'b1, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_d1: got dout=%h irqn=%b level=%0d ovf=%b, want ff 1 0 0", d1_dout, d1_irqn, d1_level, d1_ovf);
        end
    endtask

    task automatic test_single();
        do_reset();
        main_latch = 8'h12;
        main_irq = 1'b1;
        tick();
        main_irq = 1'b0;
        asserts++;
        if ({d4_irqn, d4_dout, d4_level} !== {1'b1, 8'h12, 3'd1}) begin
            fails++;
            $display("FAIL single_1clk: got irqn=%b dout=%h level=%0d, want 1 12 1", d4_irqn, d4_dout, d4_level);
        end
        tick();
        asserts++;
        if ({d4_irqn, d4_dout, d4_level} !== {1'b0, 8'h12, 3'd1}) begin
            fails++;
            $display("FAIL single_2clk: got irqn=%b dout=%h level=%0d, want 0 12 1", d4_irqn, d4_dout, d4_level);
        end
        snd_cen = 1'b1;
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        asserts++;
        if (d4_irqn !== 1'b1) begin
            fails++;
            $display("FAIL single_ack: got irqn=%b, want 1", d4_irqn);
        end
        snd_rd = 1'b1;
        tick();
        snd_rd = 1'b0;
        snd_cen = 1'b0;
        tick();
        asserts++;
        if ({d4_irqn, d4_dout, d4_level} !== {1'b1, 8'h12, 3'd0}) begin
            fails++;
            $display("FAIL single_read: got irqn=%b dout=%h level=%0d, want 1 12 0", d4_irqn, d4_dout, d4_level);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA5};
        do_reset();
        for (int i = 0; i < 5; i++) pulse(8'hA1 + 8'(i));
        asserts++;
        if ({d4_level, d4_ovf} !== {3'd4, 1'b1}) begin
            fails++;
            $display("FAIL ovf_full: got level=%0d ovf=%b, want 4 1", d4_level, d4_ovf);
        end
        asserts++;
        if ({d1_dout, d1_level, d1_ovf} !== {8'hA5, 2'd1, 1'b1}) begin
            fails++;
            $display("FAIL ovf_depth1: got dout=%h level=%0d ovf=%b, want a5 1 1", d1_dout, d1_level, d1_ovf);
        end
        snd_cen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if ({d4_irqn, d4_dout} !== {1'b0, exp[k]}) begin
                fails++;
                $display("FAIL ovf_pend%0d: got irqn=%b dout=%h, want 0 %h", k, d4_irqn, d4_dout, exp[k]);
            end
            snd_ack = 1'b1;
            tick();
            snd_ack = 1'b0;
            asserts++;
            if (d4_irqn !== 1'b1) begin
                fails++;
                $display("FAIL ovf_serv%0d: got irqn=%b, want 1", k, d4_irqn);
            end
            snd_rd = 1'b1;
            tick();
            snd_rd = 1'b0;
        end
        snd_cen = 1'b0;
        asserts++;
        if ({d4_irqn, d4_dout, d4_level, d4_ovf} !== {1'b1, 8'hA5, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL ovf_drain: got irqn=%b dout=%h level=%0d ovf=%b, want 1 a5 0 1", d4_irqn, d4_dout, d4_level, d4_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) pulse(8'h40 + 8'(i));
        snd_cen = 1'b1;
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        snd_rd = 1'b1;
        main_latch = 8'h44;
        main_irq = 1'b1;
        tick();
        snd_rd = 1'b0;
        snd_cen = 1'b0;
        main_irq = 1'b0;
        asserts++;
        if ({d4_level, d4_ovf, d4_dout, d4_irqn} !== {3'd4, 1'b0, 8'h41, 1'b0}) begin
            fails++;
            $display("FAIL full_push_pop: got level=%0d ovf=%b dout=%h irqn=%b, want 4 0 41 0", d4_level, d4_ovf, d4_dout, d4_irqn);
        end
        tick();
    endtask

    task automatic test_depth1();
        do_reset();
        pulse(8'h30);
        pulse(8'h31);
        asserts++;
        if ({d1_dout, d1_ovf, d1_level, d1_irqn} !== {8'h31, 1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL depth1_overwrite: got dout=%h ovf=%b level=%0d irqn=%b, want 31 1 1 0", d1_dout, d1_ovf, d1_level, d1_irqn);
        end
        snd_cen = 1'b1;
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
        snd_rd = 1'b1;
        tick();
        snd_rd = 1'b0;
        snd_cen = 1'b0;
        tick();
        tick();
        asserts++;
        if ({d1_irqn, d1_level, d1_dout} !== {1'b1, 2'd0, 8'h31}) begin
            fails++;
            $display("FAIL depth1_single_irq: got irqn=%b level=%0d dout=%h, want 1 0 31", d1_irqn, d1_level, d1_dout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(8'h50 + 8'(i));
        asserts++;
        if ({d4_irqn, d4_level} !== {1'b0, 3'd3}) begin
            fails++;
            $display("FAIL rstmid_pre: got irqn=%b level=%0d, want 0 3", d4_irqn, d4_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        asserts++;
        if ({d4_irqn, d4_level, d4_dout} !== {1'b1, 3'd0, 8'hFF}) begin
            fails++;
            $display("FAIL rstmid_post: got irqn=%b level=%0d dout=%h, want 1 0 ff", d4_irqn, d4_level, d4_dout);
        end
        snd_cen = 1'b1;
        snd_rd = 1'b1;
        tick();
        snd_rd = 1'b0;
        snd_cen = 1'b0;
        asserts++;
        if ({d4_irqn, d4_level, d4_dout, d4_ovf} !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
            fails++;
            $display("FAIL rstmid_read: got irqn=%b level=%0d dout=%h ovf=%b, want 1 0 ff 0", d4_irqn, d4_level, d4_dout, d4_ovf);
        end
    endtask

    task automatic test_random();
        int bad4 = 0, bad1 = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            main_irq   = ($urandom_range(0, 2) != 0) ? ~main_irq : main_irq;
            main_latch = 8'($urandom);
            snd_cen    = $urandom_range(0, 1) == 1;
            snd_rd     = $urandom_range(0, 3) == 0;
            snd_ack    = $urandom_range(0, 3) == 0;
            if (c == 300) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            tick();
            asserts++;
            if ({d4_dout, d4_irqn, d4_level, d4_ovf} !== {md[0], mph[0] != 1, 3'(mq[0].size()), movf[0]}) begin
                fails++;
                if (bad4++ < 5) $display("FAIL random_d4 cycle %0d: got %h %b %0d %b, want %h %b %0d %b", c, d4_dout, d4_irqn, d4_level, d4_ovf, md[0], mph[0] != 1, mq[0].size(), movf[0]);
            end
            asserts++;
            if ({d1_dout, d1_irqn, d1_level, d1_ovf} !== {md[1], mph[1] != 1, 2'(mq[1].size()), movf[1]}) begin
                fails++;
                if (bad1++ < 5) $display("FAIL random_d1 cycle %0d: got %h %b %0d %b, want %h %b %0d %b", c, d1_dout, d1_irqn, d1_level, d1_ovf, md[1], mph[1] != 1, mq[1].size(), movf[1]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_depth1();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
